// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on input and output.
//
// Single-cycle ops (logic, add/sub, compares, shifts) finish at the accepting
// edge. MUL runs an iterative shift-add, one multiplier bit per clock, for
// WIDTH clocks. The result and flags are registered and held until the
// consumer takes them.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operands/op valid this cycle
//   in_ready    block idle and able to accept (high only in IDLE)
//   SrcA, SrcB  operands; SrcB[SHW-1:0] is the shift amount for shifts
//   aluControl  operation select (see OP_* encodings)
//   out_valid   aluResult/zero/overflow hold a completed result
//   out_ready   consumer takes the result this cycle
//   aluResult   registered result
//   zero        aluResult == 0 (forced 0 for unsupported op codes)
//   overflow    signed overflow for ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       aluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Result/flag registers behind the output ports.
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;

  // Shift-add multiplier state: multiplicand shifts left, multiplier shifts
  // right, so bit 0 of r_mplier always selects the current partial product.
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_acc_next;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_ovf;
  logic             w_alu_known;
  logic             w_alu_zero;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (aluControl == OP_MUL);
  assign w_mul_last = (r_state == ST_BUSY) && (r_cnt == SHW'(WIDTH - 1));

  assign aluResult = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (operates directly on the live inputs; only used at
  // the accepting edge)
  // ---------------------------------------------------------------------------
  assign w_shamt = SrcB[SHW-1:0];
  assign w_sum   = SrcA + SrcB;
  assign w_diff  = SrcA - SrcB;

  // Signed overflow: operands of the same sign (B negated for SUB) produce a
  // result of the opposite sign.
  assign w_add_ovf = (SrcA[MSB] == SrcB[MSB]) && (w_sum[MSB]  != SrcA[MSB]);
  assign w_sub_ovf = (SrcA[MSB] != SrcB[MSB]) && (w_diff[MSB] != SrcA[MSB]);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_alu_result = '0;
    w_alu_ovf    = 1'b0;
    w_alu_known  = 1'b1;
    case (aluControl)
      OP_AND:  w_alu_result = SrcA & SrcB;
      OP_OR:   w_alu_result = SrcA | SrcB;
      OP_ADD:  begin
        w_alu_result = w_sum;
        w_alu_ovf    = w_add_ovf;
      end
      OP_XOR:  w_alu_result = SrcA ^ SrcB;
      OP_NOR:  w_alu_result = ~(SrcA | SrcB);
      OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SUB:  begin
        w_alu_result = w_diff;
        w_alu_ovf    = w_sub_ovf;
      end
      OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL:  w_alu_result = SrcA << w_shamt;
      OP_SRL:  w_alu_result = SrcA >> w_shamt;
      OP_SRA:  w_alu_result = $unsigned($signed(SrcA) >>> w_shamt);
      OP_MUL:  w_alu_result = '0;  // produced by the iterative path instead
      default: w_alu_known  = 1'b0;
    endcase
  end

  // Unsupported codes report result 0 with both flags clear.
  assign w_alu_zero = w_alu_known && (w_alu_result == '0);

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. Bits above WIDTH are dropped (low-half product).
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_mul_last) w_state_next = ST_DONE;
      ST_DONE: if (out_ready)  w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        // Capture operands; the result registers keep their old value until
        // the product is complete.
        r_mcand  <= SrcA;
        r_mplier <= SrcB;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_result   <= w_alu_result;
        r_zero     <= w_alu_zero;
        r_overflow <= w_alu_ovf;
      end
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mul_last) begin
        r_result   <= w_acc_next;
        r_zero     <= (w_acc_next == '0);
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- directed, table-driven bench for alu_mc at WIDTH=32.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle away from the rising edge the DUT uses.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_BAD  = 4'b1100;

  localparam int LAT_LIMIT = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       aluControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluResult;
  logic             zero;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .aluControl (aluControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluResult  (aluResult),
    .zero       (zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  // Issue one operation, wait (bounded) for out_valid, capture outputs and
  // consume the result. lat counts falling edges after the accepting edge,
  // the first one being 1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic z, output logic ov);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    aluControl = op;
    SrcA       = a;
    SrcB       = b;
    out_ready  = 1'b0;
    @(negedge clk);
    // Scramble inputs after the accept edge: the captured values must be used.
    in_valid   = 1'b0;
    SrcA       = ~a;
    SrcB       = ~b;
    aluControl = ~op;
    lat = 1;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    res = aluResult;
    z   = zero;
    ov  = overflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drops_after_take", 32'(out_valid), 32'd0);
  endtask

  initial begin : main
    int          lat;
    int          bad_ready;
    int          seen_valid;
    logic [31:0] res;
    logic        z;
    logic        ov;

    //           op       a             b             res           z     ov    lat
    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[4]  = '{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    vecs[7]  = '{OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0, 1};
    vecs[9]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_SRL,  32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
    vecs[12] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[13] = '{OP_BAD,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[14] = '{OP_MUL,  32'h00012345, 32'h00001000, 32'h12345000, 1'b0, 1'b0, 33};
    vecs[15] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33};
    vecs[16] = '{OP_SLT,  32'h00000005, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    aluControl = OP_AND;

    // Reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    aluResult,      32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);

    // First acceptance at the first rising edge after release
    @(negedge clk);
    in_valid   = 1'b1;
    aluControl = OP_ADD;
    SrcA       = 32'd10;
    SrcB       = 32'd20;
    rst_n      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_edge_out_valid", 32'(out_valid), 32'd1);
    check("first_edge_result",    aluResult,      32'd30);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("first_edge_idle", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z, ov);
      check($sformatf("v%0d_result",   i), res,      vecs[i].res);
      check($sformatf("v%0d_zero",     i), 32'(z),   32'(vecs[i].z));
      check($sformatf("v%0d_overflow", i), 32'(ov),  32'(vecs[i].ov));
      check($sformatf("v%0d_latency",  i), 32'(lat), 32'(vecs[i].lat));
    end

    // MUL with in_valid pulses and input churn while BUSY
    @(negedge clk);
    in_valid   = 1'b1;
    aluControl = OP_MUL;
    SrcA       = 32'd3;
    SrcB       = 32'd7;
    @(negedge clk);
    lat       = 1;
    bad_ready = 0;
    while (!out_valid && lat < LAT_LIMIT) begin
      if (in_ready) bad_ready++;
      in_valid   = 1'($urandom_range(0, 1));
      SrcA       = $urandom;
      SrcB       = $urandom;
      aluControl = OP_ADD;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("busy_in_ready_low", 32'(bad_ready), 32'd0);
    check("busy_mul_latency",  32'(lat),       32'd33);
    check("busy_mul_result",   aluResult,      32'd21);

    // Hold in DONE with out_ready low while inputs toggle
    for (int k = 0; k < 5; k++) begin
      in_valid   = 1'b1;
      aluControl = OP_SUB;
      SrcA       = (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678;
      SrcB       = (k % 2 == 0) ? 32'h00000001 : 32'hCAFEF00D;
      @(negedge clk);
      check($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_result",    k), aluResult,      32'd21);
      check($sformatf("hold%0d_in_ready",  k), 32'(in_ready),  32'd0);
    end
    // Take the result with in_valid still high: nothing may be accepted there
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("take_out_valid",     32'(out_valid), 32'd0);
    check("take_in_ready",      32'(in_ready),  32'd1);
    check("take_result_held",   aluResult,      32'd21);
    @(negedge clk);
    check("take_no_hidden_op",  32'(out_valid), 32'd0);

    // Reset in the middle of a MUL
    @(negedge clk);
    in_valid   = 1'b1;
    aluControl = OP_MUL;
    SrcA       = 32'h00012345;
    SrcB       = 32'h00001000;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (9) @(negedge clk);
    check("midmul_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    check("midmul_rst_result",    aluResult,      32'd0);
    check("midmul_rst_zero",      32'(zero),      32'd0);
    check("midmul_rst_overflow",  32'(overflow),  32'd0);
    check("midmul_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    seen_valid = 0;
    out_ready  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("midmul_no_out_valid", 32'(seen_valid), 32'd0);

    run_op(OP_ADD, 32'd2, 32'd3, lat, res, z, ov);
    check("post_rst_add_result",  res,       32'd5);
    check("post_rst_add_latency", 32'(lat),  32'd1);
    check("post_rst_add_zero",    32'(z),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and op are valid this cycle.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B; bits [SHW-1:0] give the shift amount for shift ops.
REQ-009 aluControl  input  4  operation select.
REQ-010 out_valid  output  1  aluResult and flags hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 aluResult  output  WIDTH  registered result.
REQ-013 zero  output  1  aluResult == 0.
REQ-014 overflow  output  1  signed overflow; ADD/SUB only, else 0.

Function
REQ-015 Op encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL; every other code yields result 0, flags 0, single-cycle latency.
REQ-016 SLT/SLTU result is 1 or 0, zero-extended to WIDTH.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; overflow = operand signs agree (after negating B for SUB) and result sign differs.
REQ-018 MUL returns the low WIDTH bits of the unsigned product, computed by an iterative shift-add, one multiplier bit per cycle.
REQ-019 States: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-020 Handshake: an operation is accepted on a rising edge with in_valid && in_ready; operands and op are captured at that edge, later input changes are ignored.
REQ-021 Non-MUL accept: IDLE -> DONE at the accepting edge; out_valid high the next cycle (latency 1).
REQ-022 MUL accept: IDLE -> BUSY; after exactly WIDTH further edges BUSY -> DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-023 DONE: aluResult, zero, overflow stable while out_valid && !out_ready.
REQ-024 DONE with out_ready high at an edge: -> IDLE, out_valid deasserts; no new op accepted at that same edge.
REQ-025 in_valid during BUSY or DONE is not accepted and has no effect.
REQ-026 out_ready while not out_valid has no effect.
REQ-027 aluResult and flags hold their last value in IDLE and BUSY; they update only on entry to DONE.

Reset
REQ-028 rst_n low: immediately, without clock, state = IDLE, out_valid = 0, aluResult = 0, zero = 0, overflow = 0, MUL accumulator and counter = 0.
REQ-029 in_ready = 1 while rst_n low and after release.
REQ-030 Reset during BUSY or DONE discards the operation; no out_valid follows.
REQ-031 First acceptance possible at the first rising edge with rst_n high.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF + 1, out_ready=1 -> next cycle out_valid=1, aluResult=0x80000000, overflow=1, zero=0.
REQ-033 SUB 5-5 then SLT 0xFFFFFFFF,1 then SLTU same -> results 0 (zero=1), 1, 0; each latency 1.
REQ-034 SRA 0x80000000 by SrcB=0x24 (amount 4) -> 0xF8000000; SLL 1 by 31 -> 0x80000000.
REQ-035 MUL 0x00012345 x 0x00001000 -> out_valid exactly 33 cycles after accept, aluResult=0x12345000; in_valid pulses during BUSY ignored, in_ready=0 throughout.
REQ-036 Result ready, out_ready held low 5 cycles with SrcA/SrcB toggling -> aluResult constant, out_valid=1; out_ready=1 -> IDLE next cycle.
REQ-037 rst_n asserted mid-MUL (cycle 10) -> outputs 0 and in_ready=1 asynchronously; no out_valid after release; next ADD 2+3 -> 5.
